norm_shift_seq: RTL



---
 rtl/norm_shift_seq.sv | 84 ++++++++
 1 files changed

// File: rtl/norm_shift_seq.sv
// norm_shift_seq: normalises an unsigned product by iterating a light left shifter until the MSB is set.
// Ports: clk/rst_n (async active-low); flush (sync abort); in_valid/in_ready/in_data (WIDTH-bit product);
// out_valid/out_ready; out_data (normalised product), out_shamt (total left shift), out_zero (input was zero).
module norm_lshift #(
  parameter int WIDTH  = 48,
  parameter int AWIDTH = 5
) (
  input  logic [WIDTH-1:0]  d,
  input  logic [AWIDTH-1:0] amt,
  output logic [WIDTH-1:0]  q
);
  assign q = d << amt;
endmodule

module norm_shift_seq #(
  parameter int WIDTH = 48
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH)-1:0]   out_shamt,
  output logic                       out_zero
);
  localparam int AWIDTH = $clog2(WIDTH) - 1;
  localparam int SWIDTH = $clog2(WIDTH);
  localparam int MAXS   = (1 << AWIDTH) - 1;
  localparam int LZW    = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0]  data_q, shifted;
  logic [SWIDTH-1:0] shamt_q;
  logic              zero_q, accept, last_pass;
  logic [LZW-1:0]    lz;
  logic [AWIDTH-1:0] step, sh_amt;
  always_comb begin
    lz = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (data_q[i]) lz = LZW'(WIDTH - 1 - i);
  end
  // Counts above MAXS are clipped to one full pass and finished on a later cycle.
  assign last_pass = lz <= LZW'(MAXS);
  assign step      = last_pass ? lz[AWIDTH-1:0] : AWIDTH'(MAXS);
  assign sh_amt    = (state == SHIFT) ? step : '0;
  norm_lshift #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) u_shift (.d(data_q), .amt(sh_amt), .q(shifted));
  assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_zero  = zero_q;
  always_comb begin
    state_n = state;
    state_n = flush                       ? IDLE :
              accept                      ? ((in_data == '0) ? DONE : SHIFT) :
              (state == SHIFT)            ? (last_pass ? DONE : SHIFT) :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (flush) begin
        zero_q <= 1'b0;
      end else if (accept) begin
        data_q  <= in_data;
        shamt_q <= '0;
        zero_q  <= (in_data == '0);
      end else if (state == SHIFT) begin
        data_q  <= shifted;
        shamt_q <= shamt_q + SWIDTH'(step);
      end
    end
  end
endmodule
